// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier returning the low 64 bits of a*b with a single-cycle write-back pulse.
// Optional macro MUL_UNIT_EARLY_EXIT_EN ends the iteration once the remaining multiplier bits are zero.
module mul_unit #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        rd,
  output logic              busy,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [4:0]        rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] mplier_sh;
  logic              last_iter;

  always_comb begin
    partial   = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_sh = mplier_q >> 1;
`ifdef MUL_UNIT_EARLY_EXIT_EN
    last_iter = (cnt_q == 6'd63) || (mplier_sh == '0);
`else
    last_iter = (cnt_q == 6'd63);
`endif
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    busy_d     = busy_q;
    wb_valid_d = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          rd_d     = rd;
          acc_d    = '0;
          cnt_d    = 6'd0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = partial;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_sh;
        cnt_d    = cnt_q + 6'd1;
        if (last_iter) begin
          // Register 31 is the hard-wired zero register: result computed, write suppressed.
          wb_data_d  = partial;
          wb_reg_d   = rd_q;
          wb_valid_d = (rd_q != 5'd31);
          state_d    = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= 6'd0;
      rd_q       <= 5'd0;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= 5'd0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign busy     = busy_q;
  assign wb_valid = wb_valid_q;
  assign wb_reg   = wb_reg_q;
  assign wb_data  = wb_data_q;

endmodule
